timer_reg_load_ctrl: RTL

//   Sequencer/arbiter in front of the timer's 32-bit byte-loaded compare register.

---
 rtl/timer_reg_load_ctrl_if.sv | 29 ++
 rtl/timer_reg_load_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/timer_reg_load_ctrl_if.sv
// Load-bus bundle between the CPU / auto-reload requesters and the compare-register
// load sequencer. The master side drives requests; the slave side is the sequencer.
interface timer_reg_load_ctrl_if;
  logic        cpu_wr;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_clr;
  logic        cpu_ready;
  logic        rl_req;
  logic [31:0] rl_word;
  logic        rl_ack;
  logic        load1;
  logic        load2;
  logic        load3;
  logic        load4;
  logic        init;
  logic [7:0]  pload;
  logic        busy;

  modport master (
    output cpu_wr, cpu_addr, cpu_wdata, cpu_clr, rl_req, rl_word,
    input  cpu_ready, rl_ack, load1, load2, load3, load4, init, pload, busy
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_wdata, cpu_clr, rl_req, rl_word,
    output cpu_ready, rl_ack, load1, load2, load3, load4, init, pload, busy
  );
endinterface

// File: rtl/timer_reg_load_ctrl.sv
// Arbitrates the compare register's 8-bit load bus between CPU byte writes/clears and
// the auto-reload engine, serialising a 32-bit reload word into four byte strobes.
module timer_reg_load_ctrl #(
  parameter bit CPU_PRIO = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  timer_reg_load_ctrl_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]  state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic [31:0] word_r, word_s;
  logic [3:0]  load_r, load_s;
  logic        init_r, init_s;
  logic [7:0]  pload_r, pload_s;
  logic        ack_r, ack_s;
  logic        rl_ok_s, cpu_win_s, rl_win_s;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // A reload still asserted in its own ack cycle must not restart the burst.
  assign rl_ok_s   = bus.rl_req && !ack_r;
  assign cpu_win_s = bus.cpu_wr && (CPU_PRIO || !rl_ok_s);
  assign rl_win_s  = rl_ok_s && !(CPU_PRIO && bus.cpu_wr);

  // Next-state and next-output decode for arbitration and burst serialisation.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    word_s  = word_r;
    load_s  = 4'b0000;
    init_s  = 1'b0;
    pload_s = 8'h00;
    ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_clr) begin
          init_s = 1'b1;
        end else if (cpu_win_s) begin
          load_s  = 4'b0001 << bus.cpu_addr;
          pload_s = bus.cpu_wdata;
        end else if (rl_win_s) begin
          word_s  = bus.rl_word;
          state_s = ST_BURST;
          idx_s   = 2'd0;
          load_s  = 4'b0001;
          pload_s = bus.rl_word[7:0];
        end else begin
          load_s = 4'b0000;
        end
      end
      ST_BURST: begin
        idx_s   = idx_r + 2'd1;
        load_s  = 4'b0001 << idx_s;
        pload_s = byte_sel(word_r, idx_s);
        // Leaving BURST on the last byte lets the CPU be accepted during load4.
        if (idx_s == 2'd3) begin
          state_s = ST_IDLE;
          ack_s   = 1'b1;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 2'd0;
      end
    endcase
  end

  // State and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      word_r  <= 32'h0000_0000;
      load_r  <= 4'b0000;
      init_r  <= 1'b0;
      pload_r <= 8'h00;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      word_r  <= word_s;
      load_r  <= load_s;
      init_r  <= init_s;
      pload_r <= pload_s;
      ack_r   <= ack_s;
    end
  end

  assign bus.cpu_ready = (state_r == ST_IDLE);
  assign bus.busy      = (state_r == ST_BURST);
  assign bus.load1     = load_r[0];
  assign bus.load2     = load_r[1];
  assign bus.load3     = load_r[2];
  assign bus.load4     = load_r[3];
  assign bus.init      = init_r;
  assign bus.pload     = pload_r;
  assign bus.rl_ack    = ack_r;

endmodule
